// File: rtl/lif_aer_arbiter.sv
// rtl/lif_aer_arbiter.sv - four-source spike capture with round-robin AER four-phase event output
module lif_aer_arbiter #(
    parameter int TS_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [3:0]          spike_in,
    input  logic                aer_ack,
    input  logic                clr_ovf,
    output logic                aer_req,
    output logic [1:0]          aer_addr,
    output logic [TS_WIDTH-1:0] aer_ts,
    output logic [3:0]          pending,
    output logic                overflow,
    output logic [7:0]          drop_cnt
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACKLOW = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] ts_cap [4];
    logic [1:0]          last;
    logic                grant;
    logic [1:0]          sel;
    logic [1:0]          cand;
    logic [3:0]          grant_vec;
    logic [3:0]          capture;
    logic [3:0]          drop;
    logic [2:0]          drop_num;
    logic [8:0]          drop_sum;

    // Round-robin search starting one past the last granted source.
    always_comb begin
        grant = 1'b0;
        sel   = last;
        cand  = last;
        if (state == IDLE && en) begin
            for (int k = 1; k <= 4; k++) begin
                cand = last + 2'(k);
                if (!grant && pending[cand]) begin
                    grant = 1'b1;
                    sel   = cand;
                end
            end
        end
    end

    // A spike on the source being granted this edge re-arms it instead of dropping.
    always_comb begin
        grant_vec = grant ? (4'b0001 << sel) : 4'b0000;
        capture   = en ? (spike_in & (~pending | grant_vec)) : 4'b0000;
        drop      = en ? (spike_in & pending & ~grant_vec) : 4'b0000;
        drop_num  = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
        drop_sum  = {1'b0, drop_cnt} + 9'(drop_num);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant)    state_nx = REQ;
            REQ:     if (aer_ack)  state_nx = ACKLOW;
            ACKLOW:  if (!aer_ack) state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ts       <= '0;
            last     <= 2'd3;
            pending  <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                ts_cap[i] <= '0;
            end
            aer_req  <= 1'b0;
            aer_addr <= 2'd0;
            aer_ts   <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            state   <= state_nx;
            if (en) begin
                ts <= ts + TS_WIDTH'(1);
            end
            pending <= (pending & ~grant_vec) | capture;
            for (int i = 0; i < 4; i++) begin
                if (capture[i]) begin
                    ts_cap[i] <= ts;
                end
            end

            if (grant) begin
                aer_req  <= 1'b1;
                aer_addr <= sel;
                aer_ts   <= ts_cap[sel];
                last     <= sel;
            end else if (state == REQ && aer_ack) begin
                aer_req  <= 1'b0;
            end

            // Drops in the clearing cycle survive the clear.
            if (clr_ovf) begin
                overflow <= |drop;
                drop_cnt <= 8'(drop_num);
            end else begin
                if (|drop) begin
                    overflow <= 1'b1;
                end
                drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
        end
    end
endmodule

// File: tb/tb_lif_aer_arbiter.sv
// tb/tb_lif_aer_arbiter.sv - randomized and directed bench for lif_aer_arbiter against an event-level model
module tb_lif_aer_arbiter;
    localparam int TSW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [3:0]     spike_in;
    logic           aer_ack;
    logic           clr_ovf;
    logic           aer_req;
    logic [1:0]     aer_addr;
    logic [TSW-1:0] aer_ts;
    logic [3:0]     pending;
    logic           overflow;
    logic [7:0]     drop_cnt;

    always #5 clk = ~clk;

    lif_aer_arbiter #(.TS_WIDTH(TSW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .spike_in (spike_in),
        .aer_ack  (aer_ack),
        .clr_ovf  (clr_ovf),
        .aer_req  (aer_req),
        .aer_addr (aer_addr),
        .aer_ts   (aer_ts),
        .pending  (pending),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: m_phase 0 = free, 1 = request raised, 2 = waiting for ack to drop.
    int m_ts, m_req, m_addr, m_tsout, m_phase, m_last, m_ovf, m_drop;
    int m_pend [4];
    int m_cap  [4];
    int ack_mode;
    int gq [$];
    logic prev_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pend_vec();
        int v = 0;
        for (int i = 0; i < 4; i++) v += m_pend[i] << i;
        return v;
    endfunction

    function automatic logic pick_ack();
        case (ack_mode)
            0:       return (m_phase == 1);
            1:       if (m_phase == 1)      return ($urandom % 3 == 0);
                     else if (m_phase == 2) return ($urandom % 3 != 0);
                     else                   return ($urandom % 8 == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_ts = 0; m_req = 0; m_addr = 0; m_tsout = 0;
        m_phase = 0; m_last = 3; m_ovf = 0; m_drop = 0;
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            m_cap[i]  = 0;
        end
    endtask

    task automatic step(input logic e, input logic [3:0] s, input logic a, input logic c);
        int g;
        int nd;
        int np [4];
        en = e; spike_in = s; aer_ack = a; clr_ovf = c;
        g = -1;
        if (m_phase == 0 && e)
            for (int k = 1; k <= 4; k++)
                if (g < 0 && m_pend[(m_last + k) % 4] != 0) g = (m_last + k) % 4;
        for (int i = 0; i < 4; i++) np[i] = m_pend[i];
        if (g >= 0) begin
            np[g] = 0;
            m_tsout = m_cap[g];
            m_addr = g;
            m_req = 1;
            m_last = g;
            m_phase = 1;
        end else if (m_phase == 1 && a) begin
            m_req = 0;
            m_phase = 2;
        end else if (m_phase == 2 && !a) begin
            m_phase = 0;
        end
        nd = 0;
        if (e)
            for (int i = 0; i < 4; i++)
                if (s[i]) begin
                    if (m_pend[i] != 0 && i != g) nd++;
                    else begin
                        np[i] = 1;
                        m_cap[i] = m_ts;
                    end
                end
        if (c) begin
            m_ovf = (nd > 0);
            m_drop = nd;
        end else begin
            if (nd > 0) m_ovf = 1;
            m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
        end
        if (e) m_ts = (m_ts + 1) % 256;
        for (int i = 0; i < 4; i++) m_pend[i] = np[i];

        @(posedge clk);
        #1;
        check("req", 32'(aer_req), 32'(m_req));
        check("addr", 32'(aer_addr), 32'(m_addr));
        check("ts", 32'(aer_ts), 32'(m_tsout));
        check("pend", 32'(pending), 32'(pend_vec()));
        check("ovf", 32'(overflow), 32'(m_ovf));
        check("drops", 32'(drop_cnt), 32'(m_drop));
        if (aer_req === 1'b1 && prev_req !== 1'b1) gq.push_back(int'(aer_addr));
        prev_req = aer_req;
    endtask

    task automatic cyc(input logic e, input logic [3:0] s, input logic c);
        step(e, s, pick_ack(), c);
    endtask

    task automatic do_reset();
        en = 1'b0; spike_in = 4'b0000; aer_ack = 1'b0; clr_ovf = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_req", 32'(aer_req), 32'd0);
        check("rst_addr", 32'(aer_addr), 32'd0);
        check("rst_ts", 32'(aer_ts), 32'd0);
        check("rst_pend", 32'(pending), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drops", 32'(drop_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        prev_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ack_mode = 0;
        prev_req = 1'b0;
        model_reset();
        do_reset();

        // Single event captured at ts=5, presented two cycles later.
        repeat (5) cyc(1, 4'b0000, 0);
        cyc(1, 4'b0100, 0);
        cyc(1, 4'b0000, 0);
        check("ev_req", 32'(aer_req), 32'd1);
        check("ev_addr", 32'(aer_addr), 32'd2);
        check("ev_ts", 32'(aer_ts), 32'd5);
        cyc(1, 4'b0000, 0);
        cyc(1, 4'b0000, 0);
        check("ev_done", 32'(aer_req), 32'd0);
        check("ev_pend", 32'(pending), 32'd0);

        // All four at once after reset: served 0,1,2,3.
        do_reset();
        gq.delete();
        cyc(1, 4'b1111, 0);
        repeat (14) cyc(1, 4'b0000, 0);
        check("all_n", 32'(gq.size()), 32'd4);
        for (int k = 0; k < gq.size() && k < 4; k++) check("all_ord", 32'(gq[k]), 32'(k));
        check("all_drop", 32'(drop_cnt), 32'd0);

        // Sources 1 and 3 re-arm after each grant and must alternate.
        gq.delete();
        cyc(1, 4'b1010, 0);
        repeat (24) cyc(1, {(m_pend[3] == 0), 1'b0, (m_pend[1] == 0), 1'b0}, 0);
        check("fair_n", 32'(gq.size() >= 6), 32'd1);
        for (int k = 0; k < gq.size(); k++) check("fair_ord", 32'(gq[k]), (k % 2 == 0) ? 32'd1 : 32'd3);

        // Drops while the consumer stalls, clear, clear racing a drop, saturation.
        do_reset();
        ack_mode = 2;
        cyc(1, 4'b0010, 0);
        cyc(1, 4'b0000, 0);
        cyc(1, 4'b0001, 0);
        cyc(1, 4'b0001, 0);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_cnt", 32'(drop_cnt), 32'd1);
        cyc(1, 4'b0000, 1);
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_cnt", 32'(drop_cnt), 32'd0);
        cyc(1, 4'b0001, 0);
        cyc(1, 4'b0001, 1);
        check("race_ovf", 32'(overflow), 32'd1);
        check("race_cnt", 32'(drop_cnt), 32'd1);
        repeat (100) cyc(1, 4'b1111, 0);
        check("sat_cnt", 32'(drop_cnt), 32'd255);
        ack_mode = 0;
        repeat (20) cyc(1, 4'b0000, 0);

        // Timestamp wrap, then reset in the middle of a handshake.
        do_reset();
        while (m_ts != 255) cyc(1, 4'b0000, 0);
        cyc(1, 4'b0001, 0);
        cyc(1, 4'b0100, 0);
        check("wrap_addr", 32'(aer_addr), 32'd0);
        check("wrap_ts", 32'(aer_ts), 32'd255);
        cyc(1, 4'b0000, 0);
        cyc(1, 4'b0000, 0);
        cyc(1, 4'b0000, 0);
        check("wrap2_req", 32'(aer_req), 32'd1);
        check("wrap2_addr", 32'(aer_addr), 32'd2);
        check("wrap2_ts", 32'(aer_ts), 32'd0);
        do_reset();

        // Random traffic, enable toggling, random consumer, occasional clears and resets.
        ack_mode = 1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 600 == 0) do_reset();
            cyc(($urandom % 8) != 0,
                ($urandom % 3 == 0) ? 4'($urandom % 16) : 4'b0000,
                ($urandom % 40) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
